// File: rtl/apb_eg_slave_pkg.sv
// rtl/apb_eg_slave_pkg.sv - shared constants, ID values and FSM state type for the APB example register bank
package apb_eg_slave_pkg;

  localparam logic [11:0] ID_BASE   = 12'hFC0;
  localparam logic [11:0] LOCK_ADDR = 12'hF00;
  localparam logic [15:0] LOCK_KEY  = 16'hA5A5;

  localparam logic [7:0] PID0 = 8'h18;
  localparam logic [7:0] PID1 = 8'hB8;
  localparam logic [7:0] PID2 = 8'h1B;
  localparam logic [7:0] PID4 = 8'h04;
  localparam logic [7:0] PID5 = 8'h00;
  localparam logic [7:0] PID6 = 8'h00;
  localparam logic [7:0] PID7 = 8'h00;
  localparam logic [7:0] CID0 = 8'h0D;
  localparam logic [7:0] CID1 = 8'hF0;
  localparam logic [7:0] CID2 = 8'h05;
  localparam logic [7:0] CID3 = 8'hB1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Word offset within the 64-byte ID window; offsets 0-3 are reserved and read 0.
  function automatic logic [7:0] id_byte(input logic [3:0] off, input logic [3:0] eco);
    logic [7:0] v;
    case (off)
      4'd4:    v = PID4;
      4'd5:    v = PID5;
      4'd6:    v = PID6;
      4'd7:    v = PID7;
      4'd8:    v = PID0;
      4'd9:    v = PID1;
      4'd10:   v = PID2;
      4'd11:   v = {eco, 4'h0};
      4'd12:   v = CID0;
      4'd13:   v = CID1;
      4'd14:   v = CID2;
      4'd15:   v = CID3;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/apb_eg_slave_wait_ctrl.sv
// rtl/apb_eg_slave_wait_ctrl.sv - access FSM with programmable wait states
// commit marks the cycle whose closing edge enters RESP; ready is high for the RESP cycle.
module apb_eg_slave_wait_ctrl
  import apb_eg_slave_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic pclk,
  input  logic preset,
  input  logic req,
  output logic commit,
  output logic ready
);

  state_t     state;
  logic [3:0] cnt;

  always_comb begin
    commit = 1'b0;
    if (state == IDLE && req && WAIT_STATES == 0)
      commit = 1'b1;
    else if (state == WAIT && cnt == 4'd0)
      commit = 1'b1;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
    end else begin
      ready <= commit;
      case (state)
        IDLE: begin
          if (req) begin
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/apb_eg_slave_regbank.sv
// rtl/apb_eg_slave_regbank.sv - APB example slave register bank with ID registers and error responses
// Optional lock register at 0xF00 when APB_EG_REGBANK_LOCK_EN is defined.
module apb_eg_slave_regbank
  import apb_eg_slave_pkg::*;
#(
  parameter int ADDRWIDTH       = 12,
  parameter int NUM_REGS        = 4,
  parameter int WAIT_STATES     = 0,
  parameter int ERR_ON_UNMAPPED = 1
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic                 read_en,
  input  logic                 write_en,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic [3:0]           ecorevnum,
  output logic [31:0]          rdata,
  output logic                 ready,
  output logic                 slverr
);

  localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [31:0]          regs [NUM_REGS];
  logic [ADDRWIDTH-3:0] word_idx;
  logic [IDXW-1:0]      reg_idx;
  logic                 data_hit, id_hit, commit;
  logic [31:0]          rd_val;
  logic                 err, do_wr;
  logic                 unused_addr_lsbs;

  assign unused_addr_lsbs = ^addr[1:0];
  assign word_idx = addr[ADDRWIDTH-1:2];
  assign reg_idx  = word_idx[IDXW-1:0];
  assign data_hit = 32'(word_idx) < NUM_REGS;
  assign id_hit   = addr[ADDRWIDTH-1:6] == ID_BASE[11:6];

`ifdef APB_EG_REGBANK_LOCK_EN
  logic lock_q, lock_hit, lock_set, lock_clr;
  assign lock_hit = addr[ADDRWIDTH-1:2] == LOCK_ADDR[11:2];
`endif

  apb_eg_slave_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_wait_ctrl (
    .pclk   (pclk),
    .preset (preset),
    .req    (read_en | write_en),
    .commit (commit),
    .ready  (ready)
  );

  always_comb begin
    rd_val = 32'h0;
    err    = 1'b0;
    do_wr  = 1'b0;
`ifdef APB_EG_REGBANK_LOCK_EN
    lock_set = 1'b0;
    lock_clr = 1'b0;
`endif
    if (read_en && write_en) begin
      err = 1'b1;
    end else if (data_hit) begin
      if (write_en) begin
`ifdef APB_EG_REGBANK_LOCK_EN
        if (lock_q) err = 1'b1;
        else        do_wr = 1'b1;
`else
        do_wr = 1'b1;
`endif
      end else begin
        rd_val = regs[reg_idx];
      end
`ifdef APB_EG_REGBANK_LOCK_EN
    end else if (lock_hit) begin
      if (write_en) begin
        // Only the two exact key words with all strobes change the lock.
        if (wstrb == 4'hF && wdata[31:16] == LOCK_KEY && wdata[15:1] == 15'h0) begin
          lock_set = wdata[0];
          lock_clr = ~wdata[0];
        end else begin
          err = 1'b1;
        end
      end else begin
        rd_val = {31'h0, lock_q};
      end
`endif
    end else if (id_hit) begin
      if (write_en) err = 1'b1;
      else          rd_val = {24'h0, id_byte(addr[5:2], ecorevnum)};
    end else begin
      err = (ERR_ON_UNMAPPED != 0);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
    end else if (commit && do_wr) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) regs[reg_idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

`ifdef APB_EG_REGBANK_LOCK_EN
  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                lock_q <= 1'b0;
    else if (commit && lock_set) lock_q <= 1'b1;
    else if (commit && lock_clr) lock_q <= 1'b0;
  end
`endif

  // Response registers are zero outside the RESP cycle.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rdata  <= 32'h0;
      slverr <= 1'b0;
    end else begin
      rdata  <= commit ? rd_val : 32'h0;
      slverr <= commit & err;
    end
  end

endmodule

// File: tb/tb_apb_eg_slave_regbank.sv
// tb/tb_apb_eg_slave_regbank.sv - table-driven bench: instance 0 has no wait states, instance 1 has three
module tb_apb_eg_slave_regbank;

  logic        pclk = 1'b0;
  logic        preset;
  logic [3:0]  ecorevnum;
  logic [11:0] addr_a  [2];
  logic        rd_en_a [2];
  logic        wr_en_a [2];
  logic [31:0] wdata_a [2];
  logic [3:0]  wstrb_a [2];
  logic [31:0] rdata_a [2];
  logic        rdy_a   [2];
  logic        err_a   [2];

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_eg_slave_regbank #(.NUM_REGS(4), .WAIT_STATES(0), .ERR_ON_UNMAPPED(1)) u_dut0 (
    .pclk(pclk), .preset(preset), .addr(addr_a[0]), .read_en(rd_en_a[0]), .write_en(wr_en_a[0]),
    .wdata(wdata_a[0]), .wstrb(wstrb_a[0]), .ecorevnum(ecorevnum),
    .rdata(rdata_a[0]), .ready(rdy_a[0]), .slverr(err_a[0])
  );

  apb_eg_slave_regbank #(.NUM_REGS(4), .WAIT_STATES(3), .ERR_ON_UNMAPPED(1)) u_dut1 (
    .pclk(pclk), .preset(preset), .addr(addr_a[1]), .read_en(rd_en_a[1]), .write_en(wr_en_a[1]),
    .wdata(wdata_a[1]), .wstrb(wstrb_a[1]), .ecorevnum(ecorevnum),
    .rdata(rdata_a[1]), .ready(rdy_a[1]), .slverr(err_a[1])
  );

  typedef struct {
    int          d;
    bit          wr;
    bit          rd;
    logic [11:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int d, input bit wr, input bit rd, input logic [11:0] a,
                     input logic [31:0] wd, input logic [3:0] st,
                     input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.d = d; v.wr = wr; v.rd = rd; v.a = a; v.wd = wd; v.st = st;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one access, waits (bounded) for ready, then steps past the RESP cycle.
  task automatic access(input int d, input bit wr, input bit rd, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output int lat, output logic [31:0] got_rd, output logic got_err);
    bit done;
    @(negedge pclk);
    addr_a[d] = a; wdata_a[d] = wd; wstrb_a[d] = st; rd_en_a[d] = rd; wr_en_a[d] = wr;
    lat = -1; got_rd = 32'hx; got_err = 1'bx; done = 0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(posedge pclk); #1;
      if (rdy_a[d]) begin
        lat = i; got_rd = rdata_a[d]; got_err = err_a[d]; done = 1;
      end
    end
    rd_en_a[d] = 1'b0; wr_en_a[d] = 1'b0;
    @(posedge pclk); #1;
    chk($sformatf("ready_pulse_width d%0d a=%03h", d, a), {31'h0, rdy_a[d]}, 32'h0);
  endtask

  task automatic run_vec(input vec_t v);
    int          lat;
    logic [31:0] r;
    logic        e;
    access(v.d, v.wr, v.rd, v.a, v.wd, v.st, lat, r, e);
    chk($sformatf("latency d%0d a=%03h", v.d, v.a), lat, (v.d == 0) ? 1 : 4);
    chk($sformatf("rdata d%0d a=%03h", v.d, v.a), r, v.exp_rd);
    chk($sformatf("slverr d%0d a=%03h", v.d, v.a), {31'h0, e}, {31'h0, v.exp_err});
  endtask

  initial begin
    vec_t v;
    preset = 1'b1;
    ecorevnum = 4'hA;
    for (int d = 0; d < 2; d++) begin
      addr_a[d] = '0; rd_en_a[d] = 0; wr_en_a[d] = 0; wdata_a[d] = '0; wstrb_a[d] = '0;
    end

    //   d  wr rd addr     wdata          strb  exp_rdata      err
    add(0, 1, 0, 12'h008, 32'h1234_5678, 4'hF, 32'h0,         0);
    add(0, 0, 1, 12'h008, 32'h0,         4'h0, 32'h1234_5678, 0);
    add(0, 0, 1, 12'h00B, 32'h0,         4'h0, 32'h1234_5678, 0);
    add(0, 1, 0, 12'h004, 32'hFFFF_FFFF, 4'hF, 32'h0,         0);
    add(0, 1, 0, 12'h004, 32'h0000_0000, 4'h5, 32'h0,         0);
    add(0, 0, 1, 12'h004, 32'h0,         4'h0, 32'hFF00_FF00, 0);
    add(0, 1, 0, 12'h00C, 32'hDEAD_BEEF, 4'h0, 32'h0,         0);
    add(0, 0, 1, 12'h00C, 32'h0,         4'h0, 32'h0,         0);
    add(0, 0, 1, 12'h010, 32'h0,         4'h0, 32'h0,         1);
    add(0, 1, 0, 12'h010, 32'h1,         4'hF, 32'h0,         1);
    add(0, 1, 0, 12'hFE0, 32'h0,         4'hF, 32'h0,         1);
    add(0, 0, 1, 12'hFE0, 32'h0,         4'h0, 32'h18,        0);
    add(0, 0, 1, 12'hFD0, 32'h0,         4'h0, 32'h04,        0);
    add(0, 0, 1, 12'hFC0, 32'h0,         4'h0, 32'h0,         0);
    add(0, 0, 1, 12'hFE8, 32'h0,         4'h0, 32'h1B,        0);
    add(0, 0, 1, 12'hFF4, 32'h0,         4'h0, 32'hF0,        0);
    add(0, 0, 1, 12'hFFC, 32'h0,         4'h0, 32'hB1,        0);
    add(0, 1, 1, 12'h008, 32'h0,         4'hF, 32'h0,         1);
    add(0, 0, 1, 12'h008, 32'h0,         4'h0, 32'h1234_5678, 0);
    add(1, 0, 1, 12'hFEC, 32'h0,         4'h0, 32'hA0,        0);
    add(1, 1, 0, 12'h000, 32'h55AA_55AA, 4'hF, 32'h0,         0);
    add(1, 0, 1, 12'h000, 32'h0,         4'h0, 32'h55AA_55AA, 0);
`ifdef APB_EG_REGBANK_LOCK_EN
    add(0, 1, 0, 12'hF00, 32'hA5A5_0001, 4'hF, 32'h0,         0);
    add(0, 0, 1, 12'hF00, 32'h0,         4'h0, 32'h1,         0);
    add(0, 1, 0, 12'h000, 32'h0000_00FF, 4'hF, 32'h0,         1);
    add(0, 0, 1, 12'h000, 32'h0,         4'h0, 32'h0,         0);
    add(0, 1, 0, 12'hF00, 32'h1234_5678, 4'hF, 32'h0,         1);
    add(0, 0, 1, 12'hF00, 32'h0,         4'h0, 32'h1,         0);
    add(0, 1, 0, 12'hF00, 32'hA5A5_0000, 4'hF, 32'h0,         0);
    add(0, 1, 0, 12'h000, 32'h0000_00FF, 4'hF, 32'h0,         0);
    add(0, 0, 1, 12'h000, 32'h0,         4'h0, 32'hFF,        0);
`else
    add(0, 0, 1, 12'hF00, 32'h0,         4'h0, 32'h0,         1);
    add(0, 1, 0, 12'hF00, 32'hA5A5_0001, 4'hF, 32'h0,         1);
`endif

    repeat (3) @(posedge pclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready d%0d", d), {31'h0, rdy_a[d]}, 32'h0);
      chk($sformatf("reset_slverr d%0d", d), {31'h0, err_a[d]}, 32'h0);
      chk($sformatf("reset_rdata d%0d", d), rdata_a[d], 32'h0);
    end
    @(negedge pclk);
    preset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a waited write aborts it.
    @(negedge pclk);
    addr_a[1] = 12'h000; wdata_a[1] = 32'h1111_1111; wstrb_a[1] = 4'hF; wr_en_a[1] = 1'b1;
    @(posedge pclk); #1;
    chk("abort_pre_ready", {31'h0, rdy_a[1]}, 32'h0);
    @(negedge pclk);
    preset = 1'b1;
    #1;
    chk("abort_in_reset_ready", {31'h0, rdy_a[1]}, 32'h0);
    @(negedge pclk);
    preset = 1'b0;
    wr_en_a[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      chk("abort_no_ready_after", {31'h0, rdy_a[1]}, 32'h0);
    end
    v = '{d: 1, wr: 0, rd: 1, a: 12'h000, wd: 32'h0, st: 4'h0, exp_rd: 32'h0, exp_err: 0};
    run_vec(v);
    v = '{d: 0, wr: 0, rd: 1, a: 12'h008, wd: 32'h0, st: 4'h0, exp_rd: 32'h0, exp_err: 0};
    run_vec(v);
    v = '{d: 1, wr: 1, rd: 0, a: 12'h000, wd: 32'hCAFE_F00D, st: 4'hF, exp_rd: 32'h0, exp_err: 0};
    run_vec(v);
    v = '{d: 1, wr: 0, rd: 1, a: 12'h000, wd: 32'h0, st: 4'h0, exp_rd: 32'hCAFE_F00D, exp_err: 0};
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_eg_slave_regbank.md
Name: apb_eg_slave_regbank

Overview:
Parametrised register-bank back end for APB example slaves. It provides NUM_REGS 32-bit read/write registers with byte strobes, a programmable wait-state handshake and an error response for illegal accesses. Peripheral/component ID registers sit at 0xFD0-0xFFC. It sits behind an APB3/APB4 interface adapter, which drives the access controls and returns ready/slverr as PREADY/PSLVERR.

Parameters:
ADDRWIDTH, 12, byte-address width; fixed at 12 (4 KB frame).
NUM_REGS, 4, number of data registers at 0x000 upward; legal range 1..256.
WAIT_STATES, 0, extra cycles before ready; legal range 0..15.
ERR_ON_UNMAPPED, 1, 1 = an unmapped access returns slverr; 0 = unmapped reads return 0 silently and unmapped writes are ignored silently.

Ports:
pclk  input  1  clock
preset  input  1  reset; asynchronous, active-high
addr  input  ADDRWIDTH  byte address; bits [1:0] are ignored
read_en  input  1  read request; held until ready
write_en  input  1  write request; held until ready
wdata  input  32  write data
wstrb  input  4  byte write strobes; wstrb[n] enables bits [8n+7:8n]
ecorevnum  input  4  ECO revision, returned in PID3[7:4]
rdata  output  32  read data; valid only while ready=1, otherwise 0
ready  output  1  access-complete pulse, one cycle wide
slverr  output  1  error flag; qualified by ready

Behaviour:
- Reset: all data registers 0; FSM in IDLE; ready=0, slverr=0, rdata=0. Reset asserted mid-access aborts the access with no register update.
- FSM states:
  - IDLE: a request (read_en or write_en) moves to WAIT when WAIT_STATES>0, otherwise to RESP.
  - WAIT: a 4-bit counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0 it moves to RESP.
  - RESP: ready=1 for one cycle, then IDLE. A new request is accepted in the cycle after RESP.
- Latency: ready is asserted WAIT_STATES+1 cycles after the request is first seen in IDLE.
- Timing of outputs: rdata, slverr and ready are all registered. Write commit and rdata capture both occur at the clock edge that enters RESP, using addr/wdata/wstrb as held at that point.
- Decode:
  - Data region: word index = addr[11:2] < NUM_REGS.
  - ID region: addr[11:6] = 6'h3F. Word offsets 0-3 read 0. Offsets 4-15 read PID4-7, PID0-3, CID0-3. PID3 reads {24'h0, ecorevnum, 4'h0}. IDs are PID0=0x18, PID1=0xB8, PID2=0x1B, PID4=0x04, CID0-3 = 0x0D/0xF0/0x05/0xB1; PID5-7 = 0.
  - Everything else is unmapped.
- Writes: per-byte update under wstrb. wstrb=0 is a legal no-op with no error. A write to the ID region has no effect and slverr=1.
- Unmapped access: rdata=0; slverr=ERR_ON_UNMAPPED.
- read_en and write_en both high: no write, rdata=0, slverr=1.
- A request dropped before ready is a protocol violation and is not checked; the FSM still completes the access.

Optional Feature:
- Macro: APB_EG_REGBANK_LOCK_EN.
- Defined: adds a lock register at 0xF00.
  - Write 0xA5A5_0001 (all strobes set) sets lock; write 0xA5A5_0000 clears it. Any other value: no change, slverr=1.
  - Read returns {31'b0, lock}. Lock resets to 0.
  - While locked, a data-register write has no effect and slverr=1. Reads are unaffected.
- Undefined: 0xF00 is unmapped; no lock logic is present.

Decomposition:
- Package apb_eg_slave_pkg holds:
  - the ID constant values;
  - region base constants: ID_BASE 0xFC0, LOCK_ADDR 0xF00, LOCK_KEY 0xA5A5;
  - the FSM state enum {IDLE, WAIT, RESP}.
- One sub-module, apb_eg_slave_wait_ctrl: the FSM and wait counter, producing the commit strobe and ready.
- Decode, storage and read mux stay in the top module.

Test Plan:
- WAIT_STATES=0, NUM_REGS=4: write 0x1234_5678 to 0x008 with wstrb=0xF, then read 0x008 -> ready 1 cycle after each request; rdata=0x1234_5678; slverr=0.
- Byte strobes: reg1=0xFFFF_FFFF, then write 0x0000_0000 with wstrb=0x5 -> read 0x004 returns 0xFF00_FF00.
- WAIT_STATES=3: read 0xFEC with ecorevnum=0xA -> ready exactly 4 cycles after the request; rdata=0x0000_00A0.
- NUM_REGS=4, ERR_ON_UNMAPPED=1: read 0x010 -> rdata=0, slverr=1. Write 0xFE0 -> slverr=1; a later read of 0xFE0 still returns 0x18.
- Assert preset in a WAIT cycle of a write to 0x000 -> ready stays 0; reg0 reads 0 after reset; the next access completes normally.
- LOCK_EN: write 0xA5A5_0001 to 0xF00, then write 0x0000_00FF to 0x000 -> slverr=1, reg0 unchanged. Write 0xA5A5_0000, then retry the write -> reg0=0xFF.
